// File: rtl/gpio_ctrl_if.sv
// gpio_ctrl_if: data-bus access port of the GPIO controller.
// The core drives the master side, the controller is the slave.
interface gpio_ctrl_if;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        write_enable;
   logic        read_enable;
   logic [31:0] read_data;

   modport master (
      output address,
      output write_data,
      output write_enable,
      output read_enable,
      input  read_data
   );

   modport slave (
      input  address,
      input  write_data,
      input  write_enable,
      input  read_enable,
      output read_data
   );
endinterface

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO with direction, atomic set/clr/tgl,
// synchronised inputs, per-pin edge capture and a level interrupt.
module gpio_ctrl #(
   parameter logic [31:0] BASE_ADDR   = 32'hA000_0000,
   parameter int          WIDTH       = 32,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   gpio_ctrl_if.slave       bus,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   typedef logic [WIDTH-1:0] pins_t;

   pins_t out_q, out_d;
   pins_t dir_q, dir_d;
   pins_t ren_q, ren_d;
   pins_t fen_q, fen_d;
   pins_t stat_q, stat_d;
   pins_t prev_q;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

   pins_t       sync;
   pins_t       wd;
   pins_t       w1c;
   pins_t       ev;
   pins_t       rd;
   logic [31:0] off;
   logic [31:0] rd_ext;

   logic sel_in, sel_out, sel_dir;
   logic sel_set, sel_clr, sel_tgl;
   logic sel_ren, sel_fen, sel_stat;

   assign off  = bus.address - BASE_ADDR;
   assign wd   = bus.write_data[WIDTH-1:0];
   assign sync = sync_q[SYNC_STAGES-1];

   // Decode the word offset inside the window; anything else selects nothing.
   always_comb begin
      sel_in   = (off == 32'h00);
      sel_out  = (off == 32'h04);
      sel_dir  = (off == 32'h08);
      sel_set  = (off == 32'h0C);
      sel_clr  = (off == 32'h10);
      sel_tgl  = (off == 32'h14);
      sel_ren  = (off == 32'h18);
      sel_fen  = (off == 32'h1C);
      sel_stat = (off == 32'h20);
   end

   // Register writes, atomic OUT updates and sticky edge status (set wins).
   always_comb begin
      out_d = out_q;
      dir_d = dir_q;
      ren_d = ren_q;
      fen_d = fen_q;
      w1c   = '0;
      if (bus.write_enable) begin
         unique case (1'b1)
            sel_out:  out_d = wd;
            sel_dir:  dir_d = wd;
            sel_set:  out_d = out_q | wd;
            sel_clr:  out_d = out_q & ~wd;
            sel_tgl:  out_d = out_q ^ wd;
            sel_ren:  ren_d = wd;
            sel_fen:  fen_d = wd;
            sel_stat: w1c   = wd;
            default:  ;
         endcase
      end
      ev     = (sync & ~prev_q & ren_q) | (~sync & prev_q & fen_q);
      stat_d = (stat_q & ~w1c) | ev;
   end

   // State registers, including the input synchroniser and edge history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q  <= '0;
         dir_q  <= '0;
         ren_q  <= '0;
         fen_q  <= '0;
         stat_q <= '0;
         prev_q <= '0;
         sync_q <= '0;
      end else begin
         out_q  <= out_d;
         dir_q  <= dir_d;
         ren_q  <= ren_d;
         fen_q  <= fen_d;
         stat_q <= stat_d;
         prev_q <= sync;
         sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      end
   end

   // Combinational read mux; upper bits and unselected reads are zero.
   always_comb begin
      rd = '0;
      unique case (1'b1)
         sel_in:   rd = sync;
         sel_out:  rd = out_q;
         sel_dir:  rd = dir_q;
         sel_ren:  rd = ren_q;
         sel_fen:  rd = fen_q;
         sel_stat: rd = stat_q;
         default:  rd = '0;
      endcase
      rd_ext            = '0;
      rd_ext[WIDTH-1:0] = rd;
      bus.read_data     = bus.read_enable ? rd_ext : 32'h0;
   end

   assign gpio_out = out_q;
   assign gpio_oe  = dir_q;
   assign irq      = |stat_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: random and directed checks of gpio_ctrl against
// a register-map level model with a pin-history queue.
module tb_gpio_ctrl;
   localparam logic [31:0] BASE = 32'hA000_0000;
   localparam int          SS   = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gpio_ctrl_if bus ();
   gpio_ctrl_if bus8 ();
   logic [31:0] pins;
   logic [31:0] gout, goe;
   logic        irq;
   logic [7:0]  pins8, gout8, goe8;
   logic        irq8;

   gpio_ctrl #(.BASE_ADDR(BASE), .WIDTH(32), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .gpio_in(pins), .gpio_out(gout), .gpio_oe(goe), .irq(irq)
   );

   gpio_ctrl #(.BASE_ADDR(BASE), .WIDTH(8), .SYNC_STAGES(SS)) dut8 (
      .clk(clk), .rst(rst), .bus(bus8),
      .gpio_in(pins8), .gpio_out(gout8), .gpio_oe(goe8), .irq(irq8)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: register values plus history of sampled pins.
   // hist[0] is the newest sample; sync = hist[SS-1], prev = hist[SS].
   logic [31:0] m_out, m_dir, m_ren, m_fen, m_stat;
   logic [31:0] hist[$];

   task automatic m_reset();
      m_out = 0; m_dir = 0; m_ren = 0; m_fen = 0; m_stat = 0;
      hist.delete();
      for (int i = 0; i <= SS; i++) hist.push_back(32'h0);
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      case (a - BASE)
         32'h00:  return hist[SS-1];
         32'h04:  return m_out;
         32'h08:  return m_dir;
         32'h18:  return m_ren;
         32'h1C:  return m_fen;
         32'h20:  return m_stat;
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_edge(input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] p);
      logic [31:0] s, pv, ev, w1c;
      s   = hist[SS-1];
      pv  = hist[SS];
      ev  = (s & ~pv & m_ren) | (~s & pv & m_fen);
      w1c = (we && (a - BASE) == 32'h20) ? d : 32'h0;
      m_stat = (m_stat & ~w1c) | ev;
      if (we) begin
         case (a - BASE)
            32'h04: m_out = d;
            32'h08: m_dir = d;
            32'h0C: m_out = m_out | d;
            32'h10: m_out = m_out & ~d;
            32'h14: m_out = m_out ^ d;
            32'h18: m_ren = d;
            32'h1C: m_fen = d;
            default: ;
         endcase
      end
      hist.push_front(p);
      void'(hist.pop_back());
   endtask

   // One bus cycle, started and finished at a falling edge.
   task automatic cyc(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] p);
      bus.write_enable = we;
      bus.read_enable  = re;
      bus.address      = a;
      bus.write_data   = d;
      pins             = p;
      #1;
      if (re) chk("rd", bus.read_data, m_read(a));
      else    chk("rd_idle", bus.read_data, 32'h0);
      @(posedge clk);
      m_edge(we, a, d, p);
      @(negedge clk);
      chk("gpio_out", gout, m_out);
      chk("gpio_oe", goe, m_dir);
      chk("irq", {31'h0, irq}, {31'h0, |m_stat});
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      cyc(1'b1, 1'b0, BASE + off, d, pins);
   endtask

   task automatic rd_now(input string tag, input logic [31:0] off,
                         input logic [31:0] exp);
      bus.write_enable = 1'b0;
      bus.read_enable  = 1'b1;
      bus.address      = BASE + off;
      #1;
      chk(tag, bus.read_data, exp);
      bus.read_enable  = 1'b0;
   endtask

   logic [31:0] offs[11];
   initial begin
      offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
               32'h18, 32'h1C, 32'h20, 32'h24, 32'hFFFF_FFFC};

      rst = 1'b1;
      pins = 32'hFFFF_FFFF;
      pins8 = 8'hFF;
      bus.write_enable = 0; bus.read_enable = 0;
      bus.address = 0; bus.write_data = 0;
      bus8.write_enable = 0; bus8.read_enable = 0;
      bus8.address = 0; bus8.write_data = 0;
      m_reset();
      repeat (3) @(negedge clk);

      // Reset state with all pins high
      chk("rst_gout", gout, 0);
      chk("rst_goe", goe, 0);
      chk("rst_irq", {31'h0, irq}, 0);
      for (int i = 0; i < 9; i++) rd_now("rst_rd", offs[i], 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) cyc(0, 1, BASE, 0, pins);
      rd_now("in_after_sync", 32'h00, 32'hFFFF_FFFF);

      // Atomic OUT updates
      pins = 32'h0;
      for (int i = 0; i < 4; i++) cyc(0, 0, BASE, 0, pins);
      wr(32'h04, 32'h0000_00F0);
      wr(32'h0C, 32'h0000_000F);
      wr(32'h10, 32'h0000_0030);
      wr(32'h14, 32'h0000_0101);
      rd_now("t2_out", 32'h04, 32'h0000_01CE);
      chk("t2_gout", gout, 32'h0000_01CE);
      rd_now("t2_set_wo", 32'h0C, 32'h0);

      // Rising edge on pin 0, irq then W1C
      wr(32'h18, 32'h1);
      cyc(0, 0, BASE, 0, 32'h1);
      cyc(0, 0, BASE, 0, 32'h1);
      chk("t3_irq_early", {31'h0, irq}, 0);
      rd_now("t3_in", 32'h00, 32'h1);
      cyc(0, 0, BASE, 0, 32'h1);
      chk("t3_irq", {31'h0, irq}, 1);
      rd_now("t3_stat", 32'h20, 32'h1);
      wr(32'h20, 32'h1);
      chk("t3_irq_clr", {31'h0, irq}, 0);

      // Fall on pin 2 coinciding with its W1C: set wins
      wr(32'h1C, 32'h4);
      for (int i = 0; i < 4; i++) cyc(0, 0, BASE, 0, 32'h5);
      for (int i = 0; i < 3; i++) cyc(0, 0, BASE, 0, 32'h1);
      rd_now("t4_stat_pre", 32'h20, 32'h4);
      for (int i = 0; i < 4; i++) cyc(0, 0, BASE, 0, 32'h5);
      cyc(0, 0, BASE, 0, 32'h1);
      cyc(0, 0, BASE, 0, 32'h1);
      cyc(1, 0, BASE + 32'h20, 32'h4, 32'h1);
      rd_now("t4_stat_kept", 32'h20, 32'h4);
      wr(32'h20, 32'h4);
      rd_now("t4_stat_clr", 32'h20, 32'h0);

      // Unmapped addresses
      cyc(1, 1, BASE + 32'h24, 32'hFFFF_FFFF, pins);
      cyc(1, 1, BASE - 32'h4, 32'hFFFF_FFFF, pins);
      rd_now("t5_out", 32'h04, 32'h0000_01CE);
      rd_now("t5_ren", 32'h18, 32'h1);
      rd_now("t5_fen", 32'h1C, 32'h4);

      // Narrow instance ignores upper write bits
      bus8.write_enable = 1; bus8.address = BASE + 32'h04;
      bus8.write_data = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      bus8.write_enable = 0; bus8.read_enable = 1;
      #1;
      chk("w8_out", bus8.read_data, 32'h0000_00FF);
      chk("w8_gout", {24'h0, gout8}, 32'h0000_00FF);
      bus8.read_enable = 0;

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         logic [31:0] p;
         p = ($urandom_range(0, 3) == 0) ? pins ^ $urandom : pins;
         cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
             BASE + offs[$urandom_range(0, 10)], $urandom, p);
      end

      // Async reset mid-cycle with pending status and OUT
      wr(32'h04, 32'hA5);
      wr(32'h18, 32'h3);
      wr(32'h1C, 32'h0);
      wr(32'h20, 32'hFFFF_FFFF);
      for (int i = 0; i < 4; i++) cyc(0, 0, BASE, 0, 32'h0);
      wr(32'h20, 32'hFFFF_FFFF);
      for (int i = 0; i < 4; i++) cyc(0, 0, BASE, 0, 32'h3);
      rd_now("t6_stat", 32'h20, 32'h3);
      rd_now("t6_out", 32'h04, 32'hA5);
      rst = 1'b1;
      #1;
      chk("t6_irq_async", {31'h0, irq}, 0);
      chk("t6_gout_async", gout, 0);
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 9; i++) rd_now("t6_rd", offs[i], 32'h0);
      for (int i = 0; i < 4; i++) cyc(0, 1, BASE + 32'h20, 0, 32'h3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
